serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  producer presents an operand set.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in for the addition.
REQ-009 out_valid  output  1  sum and cout hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  WIDTH  registered result (a + b + cin) mod 2^WIDTH.
REQ-012 cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-013 Computation SHALL be bit-serial, LSB first, one bit per clock, through a single 1-bit full-adder cell plus a carry register.
REQ-014 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0. in_valid=1 at an edge SHALL latch a, b into shift registers, load carry from cin, clear the bit counter and go to RUN.
REQ-016 RUN: in_ready=0, out_valid=0. Each edge SHALL add the current LSBs of A and B with the carry, shift the sum bit into the result register MSB-first-in so that bit i lands at sum[i], shift A and B right and update the carry.
REQ-017 Bit counter SHALL count 0..WIDTH-1. The edge that processes bit WIDTH-1 SHALL go to DONE and SHALL capture the final carry into cout.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH edges after the accepting edge.
REQ-019 DONE: out_valid=1, in_ready=0. sum and cout SHALL stay stable until an edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-020 in_valid SHALL be ignored while not in IDLE. Operand and cin changes during RUN or DONE SHALL NOT affect the result.
REQ-021 out_ready outside DONE SHALL have no effect.
REQ-022 Throughput: at most one operation per WIDTH+2 cycles when in_valid and out_ready are held high.
REQ-023 sum and cout SHALL retain their last value in IDLE and RUN. Only out_valid qualifies them.
REQ-024 Arithmetic SHALL be unsigned. cout SHALL equal bit WIDTH of a + b + cin.

Reset
REQ-025 rst=1 SHALL immediately, without a clock, force FSM=IDLE, counter=0, carry=0, sum=0, cout=0, out_valid=0 and in_ready=1.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no result produced. The first edge after deassertion SHALL behave as IDLE.

Structure
REQ-027 Shared package serial_adder_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-028 The 1-bit add SHALL be one instance of the existing full_adder sub-module (ports a, b, cin, sum, cout). No other sub-modules.
REQ-029 The counter SHALL be sized clog2(WIDTH) bits. No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Verification (WIDTH=8)
REQ-030 a=0x0F, b=0x01, cin=0 accepted -> out_valid exactly 8 edges later, sum=0x10, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Separately, a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 Backpressure: out_ready=0 for 5 cycles after out_valid -> sum and cout stable, in_ready=0 throughout. out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 Busy: while in RUN, change a, b, cin and pulse in_valid -> the original result is unaffected and the second set is not accepted.
REQ-034 Reset mid-op: assert rst 3 edges after accept -> outputs cleared immediately. Next op a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
REQ-035 Random: 1000 operand triples with random in_valid/out_ready gaps -> each result matches (a+b+cin), checked by a scoreboard.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell used by the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit per clock, LSB first, through one full-adder cell.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic               w_last;
  logic               w_accept;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = (r_state == IDLE) && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Handshake outputs decode from state only, so no input reaches them combinationally.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A doubles as the partial-sum register: each sum bit enters at the MSB as A shifts
  // right, so after WIDTH shifts bit i of the sum sits at position i.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end else if (r_state == RUN) begin
      r_a <= {w_fa_sum, r_a[WIDTH-1:1]};
      r_b <= {1'b0, r_b[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_carry <= w_fa_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= {w_fa_sum, r_a[WIDTH-1:1]};
        r_cout <= w_fa_cout;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus a randomized scoreboard run.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int n_vec = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle. busy=1 keeps presenting fresh operands
  // with in_valid high while the operation is in flight.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tcin, input int hold, input bit busy);
    logic [W:0] exp;
    logic [W:0] held;
    int lat;
    exp = (W+1)'(ta) + (W+1)'(tb_) + (W+1)'(tcin);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tcin; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      in_valid = busy ? 1'($urandom) : 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_result"}, 32'({cout, sum}), 32'(exp));
    held = {cout, sum};
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_result"}, 32'({cout, sum}), 32'(held));
      check({tag, "_hold_hs"}, 32'({out_valid, in_ready}), 32'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  // Scoreboard for the random phase, sampled on the falling edge.
  logic [W:0] sb_q[$];
  bit         sb_on = 1'b0;
  int         n_acc = 0;
  int         n_done = 0;
  logic       prev_wait = 1'b0;
  logic [W:0] prev_res = '0;

  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (out_valid && prev_wait)
        check("rand_done_stable", 32'({cout, sum}), 32'(prev_res));
      prev_wait = out_valid && !out_ready;
      prev_res  = {cout, sum};
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("rand_unexpected_result", 32'd1, 32'd0);
        else check("rand_result", 32'({cout, sum}), 32'(sb_q.pop_front()));
        n_done++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(cin));
        n_acc++;
      end
    end
  end

  initial begin
    int cyc;
    logic bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    check("reset_outputs", 32'({in_ready, out_valid, cout, sum}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_idle", 32'({in_ready, out_valid}), 32'b10);

    do_op("basic",   8'h0F, 8'h01, 1'b0, 0, 1'b0);
    do_op("wrap",    8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op("allones", 8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    do_op("bp",      8'hA5, 8'h3C, 1'b1, 5, 1'b0);
    do_op("busy",    8'h81, 8'h7E, 1'b0, 2, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      if (!in_ready || out_valid) bad = 1'b1;
    end
    check("busy_no_second_op", 32'(bad), 32'd0);

    // Reset three edges into an operation: nothing must come out of it.
    a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_outputs", 32'({in_ready, out_valid, cout, sum}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) bad = 1'b1;
    end
    check("midrst_abandoned", 32'(bad), 32'd0);
    do_op("after_rst", 8'h12, 8'h34, 1'b0, 0, 1'b0);

    // Random phase: gaps and noise on every input, results checked by the scoreboard.
    sb_on = 1'b1;
    cyc = 0;
    while (n_done < 1000 && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      in_valid  = (n_acc < 1000) && ($urandom_range(0, 2) == 0);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    sb_on = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    check("rand_completed", 32'(n_done), 32'd1000);
    check("rand_accepted", 32'(n_acc), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
